// File: rtl/display_scan_ctrl.sv
// Four-digit display scan controller: prescaled digit select, anode dead time and frame-synchronised display commit.
// Optional define LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1 during their lit slot.
module display_scan_ctrl #(
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] din_i,
    output logic [1:0]  sel_o,
    output logic [15:0] disp_o,
    output logic [3:0]  digit_n_o,
    output logic        frame_tick_o,
    output logic        busy_o
);

    // state   | meaning
    // ST_SHOW | anode of digit sel lit for PRESCALE cycles
    // ST_DEAD | all anodes off for DEAD_CYCLES cycles while the mux settles on the new sel
    localparam logic [0:0] ST_SHOW = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    localparam logic             HAS_DEAD  = (DEAD_CYCLES > 0);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [0:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       sel_q,     sel_d;
    logic [3:0]       digit_n_q, digit_n_d;
    logic [15:0]      disp_q,    disp_d;
    logic [15:0]      pending_q, pending_d;
    logic             busy_q,    busy_d;
    logic             ft_q,      ft_d;
    logic             commit;
    logic [3:0]       blank_mask;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        commit    = 1'b0;

        if (en_i) begin
            case (state_q)
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d   = '0;
                        sel_d   = sel_q + 2'd1;
                        commit  = (sel_q == 2'd3);
                        state_d = HAS_DEAD ? ST_DEAD : ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                end
            endcase
        end

        ft_d = commit;

        // Commit uses the pending value as it stood before this edge, so a coincident load waits a frame.
        if (commit && busy_q) begin
            disp_d = pending_q;
            busy_d = 1'b0;
        end
        if (load_i) begin
            pending_d = din_i;
            busy_d    = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_mask = {~|disp_d[15:12], ~|disp_d[15:8], ~|disp_d[15:4], 1'b0};
`else
    assign blank_mask = 4'b0000;
`endif

    // Anodes are computed from next-state values so they stay registered yet aligned with sel.
    always_comb begin
        digit_n_d = digit_n_q;
        if (en_i) begin
            if (state_d == ST_SHOW) begin
                digit_n_d = ~(4'b0001 << sel_d) | blank_mask;
            end else begin
                digit_n_d = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_SHOW;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            digit_n_q <= 4'b1110;
            disp_q    <= 16'h0000;
            pending_q <= 16'h0000;
            busy_q    <= 1'b0;
            ft_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            digit_n_q <= digit_n_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            ft_q      <= ft_d;
        end
    end

    assign sel_o        = sel_q;
    assign disp_o       = disp_q;
    assign digit_n_o    = digit_n_q;
    assign frame_tick_o = ft_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: PRESCALE=4 with DEAD_CYCLES=2 (dut_a) and DEAD_CYCLES=0 (dut_b).
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, load;
    logic [15:0] din;

    logic [1:0]  a_sel, b_sel;
    logic [15:0] a_disp, b_disp;
    logic [3:0]  a_dn, b_dn;
    logic        a_ft, b_ft, a_busy, b_busy;

    display_scan_ctrl #(.PRESCALE(4), .DEAD_CYCLES(2), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .din_i(din),
        .sel_o(a_sel), .disp_o(a_disp), .digit_n_o(a_dn),
        .frame_tick_o(a_ft), .busy_o(a_busy)
    );

    display_scan_ctrl #(.PRESCALE(4), .DEAD_CYCLES(0), .CNT_W(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .din_i(din),
        .sel_o(b_sel), .disp_o(b_disp), .digit_n_o(b_dn),
        .frame_tick_o(b_ft), .busy_o(b_busy)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        load;
        logic [15:0] din;
        int          reps;
        logic [1:0]  sel;
        logic [3:0]  dn;
        logic [15:0] disp;
        logic        busy;
        logic        ft;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic r, input logic e, input logic l, input logic [15:0] d,
                                input int reps, input logic [1:0] s, input logic [3:0] dn,
                                input logic [15:0] dp, input logic b, input logic f);
        vec_t v;
        v.rst = r; v.en = e; v.load = l; v.din = d; v.reps = reps;
        v.sel = s; v.dn = dn; v.disp = dp; v.busy = b; v.ft = f;
        vecs.push_back(v);
    endfunction

    // Anodes forced off by leading-zero blanking for a given committed value.
    function automatic logic [3:0] lzb(input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
        return {d[15:12] == 4'h0, d[15:8] == 8'h00, d[15:4] == 12'h000, 1'b0};
`else
        return 4'b0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Adds one full SHOW/DEAD sequence from digit 1 through digit 3 at a fixed disp/busy.
    function automatic void add_frame_body(input logic [15:0] dp, input logic b);
        add(0, 1, 0, 16'h0, 2, 2'd1, 4'hF, dp, b, 0);
        add(0, 1, 0, 16'h0, 4, 2'd1, 4'hD, dp, b, 0);
        add(0, 1, 0, 16'h0, 2, 2'd2, 4'hF, dp, b, 0);
        add(0, 1, 0, 16'h0, 4, 2'd2, 4'hB, dp, b, 0);
        add(0, 1, 0, 16'h0, 2, 2'd3, 4'hF, dp, b, 0);
        add(0, 1, 0, 16'h0, 4, 2'd3, 4'h7, dp, b, 0);
    endfunction

    initial begin
        logic [3:0]  exp_dn;
        logic [1:0]  exp_sel;
        logic        exp_ft;
        logic [3:0]  seen_lit;
        int          waited;

        rst = 1'b1; en = 1'b1; load = 1'b0; din = 16'h0;

        // reset, then one undisturbed frame
        add(1, 1, 0, 16'h0,    2, 2'd0, 4'hE, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0,    3, 2'd0, 4'hE, 16'h0000, 0, 0);
        add_frame_body(16'h0000, 0);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h0000, 0, 1);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0,    3, 2'd0, 4'hE, 16'h0000, 0, 0);
        // mid-frame load stays pending until the commit
        add(0, 1, 1, 16'h1234, 1, 2'd0, 4'hE, 16'h0000, 1, 0);
        add_frame_body(16'h0000, 1);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h1234, 0, 1);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h1234, 0, 0);
        add(0, 1, 0, 16'h0,    3, 2'd0, 4'hE, 16'h1234, 0, 0);
        // pending AAAA, then 5555 loaded exactly on the commit edge
        add(0, 1, 1, 16'hAAAA, 1, 2'd0, 4'hE, 16'h1234, 1, 0);
        add_frame_body(16'h1234, 1);
        add(0, 1, 1, 16'h5555, 1, 2'd0, 4'hF, 16'hAAAA, 1, 1);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'hAAAA, 1, 0);
        add(0, 1, 0, 16'h0,    3, 2'd0, 4'hE, 16'hAAAA, 1, 0);
        // freeze at cnt=2 for 10 cycles, then the remaining count resumes
        add(0, 0, 0, 16'h0,   10, 2'd0, 4'hE, 16'hAAAA, 1, 0);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hE, 16'hAAAA, 1, 0);
        add_frame_body(16'hAAAA, 1);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h5555, 0, 1);
        // load then reset mid-scan: pending is discarded
        add(0, 1, 1, 16'h0F0F, 1, 2'd0, 4'hF, 16'h5555, 1, 0);
        add(1, 1, 0, 16'h0,    2, 2'd0, 4'hE, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0,    3, 2'd0, 4'hE, 16'h0000, 0, 0);
        add_frame_body(16'h0000, 0);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h0000, 0, 1);
        add(0, 1, 0, 16'h0,    1, 2'd0, 4'hF, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;
            en   = vecs[i].en;
            load = vecs[i].load;
            din  = vecs[i].din;
            exp_dn = vecs[i].dn | lzb(vecs[i].disp);
            for (int k = 0; k < vecs[i].reps; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d.%0d sel", i, k),   16'(a_sel),  16'(vecs[i].sel));
                chk($sformatf("v%0d.%0d dn", i, k),    16'(a_dn),   16'(exp_dn));
                chk($sformatf("v%0d.%0d disp", i, k),  a_disp,      vecs[i].disp);
                chk($sformatf("v%0d.%0d busy", i, k),  16'(a_busy), 16'(vecs[i].busy));
                chk($sformatf("v%0d.%0d ft", i, k),    16'(a_ft),   16'(vecs[i].ft));
            end
        end

        // zero dead time: sel advances every 4 cycles with no all-off cycle
        rst = 1'b1; en = 1'b1; load = 1'b0; din = 16'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("b reset dn", 16'(b_dn), 16'(4'hE));
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            exp_sel = 2'((e / 4) % 4);
            exp_dn  = ~(4'b0001 << exp_sel) | lzb(16'h0000);
            exp_ft  = (e == 16);
            chk($sformatf("b e%0d sel", e), 16'(b_sel), 16'(exp_sel));
            chk($sformatf("b e%0d dn", e),  16'(b_dn),  16'(exp_dn));
            chk($sformatf("b e%0d ft", e),  16'(b_ft),  16'(exp_ft));
        end

`ifdef LEADING_ZERO_BLANK_EN
        // disp=0070: digits 3 and 2 stay dark for a whole frame, digits 1 and 0 light
        load = 1'b1; din = 16'h0070;
        @(posedge clk);
        #1;
        load = 1'b0;
        waited = 0;
        while (!a_ft && waited < 60) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("lzb commit seen", 16'(a_ft), 16'(1'b1));
        chk("lzb disp", a_disp, 16'h0070);
        seen_lit = 4'b0000;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            seen_lit = seen_lit | ~a_dn;
        end
        chk("lzb lit digits", 16'(seen_lit), 16'(4'b0011));
`else
        seen_lit = 4'b0000;
        waited = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
